// File: rtl/uart_tx_gen2_pkg.sv
// Shared types, parity encodings and helpers for the uart_tx_gen2 transmitter.
package uart_tx_gen2_pkg;

  localparam int unsigned OVS = 16;

  localparam logic [1:0] ParNone = 2'b00;
  localparam logic [1:0] ParEven = 2'b01;
  localparam logic [1:0] ParOdd  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  function automatic logic [3:0] clamp_dbits(input logic [3:0] dbits, input int unsigned max_bits);
    if (dbits < 4'd5) return 4'd5;
    if ({28'd0, dbits} > max_bits) return 4'(max_bits);
    return dbits;
  endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Baud generator: divisor counter feeding an oversample tick counter; bit_end marks
// the last clock of every bit period.
module uart_tx_baud_gen
  import uart_tx_gen2_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  localparam int unsigned TickW = $clog2(OVS);

  logic [DIV_W-1:0] div_cnt_q;
  logic [TickW-1:0] tick_cnt_q;
  logic             tick;

  always_comb begin
    tick    = (div_cnt_q == div);
    bit_end = tick && (tick_cnt_q == TickW'(OVS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
    end else if (tick) begin
      div_cnt_q  <= '0;
      tick_cnt_q <= tick_cnt_q + 1'b1;
    end else begin
      div_cnt_q  <= div_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_gen2.sv
// UART transmitter with an inline transmit FIFO, configurable framing, parity and
// break generation.
module uart_tx_gen2
  import uart_tx_gen2_pkg::*;
#(
  parameter int unsigned DATA_MAX   = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic                          cfg_txen,
  input  logic [3:0]                    cfg_dbits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_nstop,
  input  logic                          cfg_break,
  input  logic                          tx_valid,
  input  logic [DATA_MAX-1:0]           tx_data,
  output logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic                          uart_txd
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = AW + 1;

  logic [DATA_MAX-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]     count_q;
  logic                push, pop;
  logic [DATA_MAX-1:0] head;

  state_e              state_q, state_d;
  logic [DATA_MAX-1:0] shift_q, shift_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                brk_rel_q, brk_rel_d;
  logic [3:0]          dbits_q;
  logic [1:0]          par_mode_q;
  logic                nstop_q;
  logic                par_q;
  logic [DIV_W-1:0]    div_q;

  logic [3:0]          dbits_cl;
  logic [DATA_MAX-1:0] data_mask;
  logic                par_bit;
  logic                has_parity;
  logic                baud_clr;
  logic                bit_end;
  logic                done;
  logic                txd;

  assign tx_ready = (count_q < LvlW'(FIFO_DEPTH));
  assign push     = tx_valid && tx_ready;
  assign head     = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  // Parity is taken over the bits that will actually be shifted out.
  always_comb begin
    dbits_cl  = clamp_dbits(cfg_dbits, DATA_MAX);
    data_mask = '0;
    for (int i = 0; i < DATA_MAX; i++) begin
      data_mask[i] = (i < int'(dbits_cl));
    end
    par_bit    = (^(head & data_mask)) ^ (cfg_parity == ParOdd);
    has_parity = !((par_mode_q == ParNone) || (par_mode_q == 2'b11));
  end

  uart_tx_baud_gen #(
    .DIV_W(DIV_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clr    (baud_clr),
    .div    (div_q),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    brk_rel_d  = brk_rel_q;
    pop        = 1'b0;
    baud_clr   = 1'b0;
    done       = 1'b0;
    txd        = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (cfg_break) begin
          state_d   = StBreak;
          brk_rel_d = 1'b0;
        end else if (cfg_txen && (count_q != '0)) begin
          state_d    = StStart;
          pop        = 1'b1;
          baud_clr   = 1'b1;
          shift_d    = head;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
        end
      end
      StStart: begin
        txd = 1'b0;
        if (bit_end) state_d = StData;
      end
      StData: begin
        txd = shift_q[0];
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == dbits_q - 4'd1) begin
            state_d = has_parity ? StParity : StStop;
          end
        end
      end
      StParity: begin
        txd = par_q;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (nstop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StBreak: begin
        // Hold the line low until release, then one full bit time of mark.
        if (!brk_rel_q) begin
          txd = 1'b0;
          if (!cfg_break) begin
            brk_rel_d = 1'b1;
            baud_clr  = 1'b1;
          end
        end else if (bit_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      brk_rel_q  <= 1'b0;
      dbits_q    <= 4'd8;
      par_mode_q <= ParNone;
      nstop_q    <= 1'b0;
      par_q      <= 1'b0;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      brk_rel_q  <= brk_rel_d;
      if (state_q == StIdle) div_q <= cfg_div;
      if (pop) begin
        dbits_q    <= dbits_cl;
        par_mode_q <= cfg_parity;
        nstop_q    <= cfg_nstop;
        par_q      <= par_bit;
      end
    end
  end

  assign uart_txd   = rst | txd;
  assign tx_busy    = !rst && (state_q != StIdle);
  assign tx_done    = !rst && done;
  assign fifo_level = rst ? '0 : count_q;

endmodule

// File: tb/tb_uart_tx_gen2.sv
// Directed bench for uart_tx_gen2: logs the line every cycle and decodes frames from
// the log against hand-computed bit patterns and timing.
module tb_uart_tx_gen2;

  localparam int LOG_N = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_div;
  logic        cfg_txen;
  logic [3:0]  cfg_dbits;
  logic [1:0]  cfg_parity;
  logic        cfg_nstop;
  logic        cfg_break;
  logic        tx_valid;
  logic [8:0]  tx_data;
  logic        tx_ready;
  logic [3:0]  fifo_level;
  logic        tx_busy;
  logic        tx_done;
  logic        uart_txd;

  always #5 clk = ~clk;

  uart_tx_gen2 dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_div   (cfg_div),
    .cfg_txen  (cfg_txen),
    .cfg_dbits (cfg_dbits),
    .cfg_parity(cfg_parity),
    .cfg_nstop (cfg_nstop),
    .cfg_break (cfg_break),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .fifo_level(fifo_level),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .uart_txd  (uart_txd)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic       txd_log  [LOG_N];
  logic       done_log [LOG_N];
  logic       busy_log [LOG_N];
  logic [3:0] lvl_log  [LOG_N];

  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      txd_log[cyc]  <= uart_txd;
      done_log[cyc] <= tx_done;
      busy_log[cyc] <= tx_busy;
      lvl_log[cyc]  <= fifo_level;
    end
    cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int idx(input int i);
    return (i < 0 || i >= LOG_N) ? 0 : i;
  endfunction

  function automatic int find_low(input int from);
    if (from < 0) return -1;
    for (int i = from; i < cyc && i < LOG_N; i++) if (txd_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int find_high(input int from);
    if (from < 0) return -1;
    for (int i = from; i < cyc && i < LOG_N; i++) if (txd_log[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int find_not_busy(input int from);
    if (from < 0) return -1;
    for (int i = from; i < cyc && i < LOG_N; i++) if (busy_log[i] === 1'b0) return i;
    return -1;
  endfunction

  function automatic int find_done(input int from);
    if (from < 0) return -1;
    for (int i = from; i < cyc && i < LOG_N; i++) if (done_log[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_done(input int from, input int upto);
    int n = 0;
    if (from < 0) return -1;
    for (int i = from; i < upto && i < LOG_N; i++) if (done_log[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int low_run(input int s);
    int n = 0;
    if (s < 0) return -1;
    while (s + n < cyc && s + n < LOG_N && txd_log[s + n] === 1'b0) n++;
    return n;
  endfunction

  // Samples each bit in the middle of its period, bit 0 being the start bit.
  function automatic int frame_val(input int s, input int bitlen, input int nbits);
    int v = 0;
    if (s < 0) return -1;
    for (int i = 0; i < nbits; i++) begin
      if (txd_log[idx(s + bitlen / 2 + i * bitlen)] === 1'b1) v |= (1 << i);
    end
    return v;
  endfunction

  task automatic push(input logic [8:0] d);
    @(negedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int n = 0;
    while ((tx_busy || fifo_level != 4'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, n < budget, 1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Configuration is scrambled once the frame is under way; the frame must not notice.
  task automatic run_frame(input string tag, input logic [15:0] div, input logic [3:0] dbits,
                           input logic [1:0] par, input logic nstop, input logic [8:0] d,
                           input int nbits, input int exp_val, output int s);
    int t0, dn, bl;
    bl = 16 * (int'(div) + 1);
    @(negedge clk);
    #1;
    cfg_div    = div;
    cfg_dbits  = dbits;
    cfg_parity = par;
    cfg_nstop  = nstop;
    t0         = cyc;
    push(d);
    repeat (5) @(negedge clk);
    #1;
    cfg_div    = 16'd1;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_nstop  = 1'b0;
    wait_quiet({tag, "_timeout"}, 4000);
    s  = find_low(t0);
    dn = find_done(t0);
    check({tag, "_bits"}, frame_val(s, bl, nbits), exp_val);
    check({tag, "_len"}, dn - s, nbits * bl - 1);
    check({tag, "_ndone"}, count_done(t0, cyc), 1);
  endtask

  initial begin
    int s, s2, dn, pd, t0, from, rel, m, n;
    rst        = 1'b1;
    cfg_div    = '0;
    cfg_txen   = 1'b0;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_nstop  = 1'b0;
    cfg_break  = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;

    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_level", fifo_level, 0);
    #1;
    rst = 1'b0;
    check("rst_ready", tx_ready, 1);
    cfg_txen = 1'b1;

    run_frame("8n1_a5", 16'd3, 4'd8, 2'b00, 1'b0, 9'h0A5, 10, 842, s);
    check("8n1_start_len", low_run(s), 64);
    run_frame("7e2_55", 16'd0, 4'd7, 2'b01, 1'b1, 9'h055, 11, 1706, s);
    run_frame("9o1_1ff", 16'd0, 4'd9, 2'b10, 1'b0, 9'h1FF, 12, 3070, s);
    run_frame("9n1_100", 16'd0, 4'd9, 2'b00, 1'b0, 9'h100, 11, 1536, s);
    run_frame("clamp5_e", 16'd0, 4'd3, 2'b01, 1'b0, 9'h0FF, 8, 254, s);
    run_frame("clamp9_p3", 16'd0, 4'd15, 2'b11, 1'b0, 9'h1FF, 11, 2046, s);

    // FIFO fill with transmit disabled, then drain.
    @(negedge clk);
    #1;
    cfg_txen   = 1'b0;
    cfg_div    = 16'd0;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_nstop  = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("full_ready", tx_ready, (i < 8));
      #1;
      tx_valid = 1'b1;
      tx_data  = (i == 8) ? 9'h0EE : 9'(16 + i);
    end
    @(negedge clk);
    #1;
    tx_valid = 1'b0;
    check("full_level", fifo_level, 8);
    check("full_ready_low", tx_ready, 0);
    t0       = cyc;
    cfg_txen = 1'b1;
    wait_quiet("fifo_timeout", 3000);
    from = t0;
    pd   = -1;
    for (int k = 0; k < 8; k++) begin
      s  = find_low(from);
      dn = find_done(from);
      check("fifo_data", frame_val(s, 16, 10), ((16 + k) << 1) | 512);
      check("fifo_level_pop", lvl_log[idx(s)], 7 - k);
      check("fifo_len", dn - s, 159);
      if (k > 0) check("fifo_gap", s - pd, 2);
      pd   = dn;
      from = dn + 1;
    end
    repeat (40) @(negedge clk);
    #1;
    check("fifo_no_9th", find_low(from), -1);
    check("fifo_ndone", count_done(t0, cyc), 8);

    // Break requested mid-frame.
    @(negedge clk);
    #1;
    t0 = cyc;
    push(9'h00F);
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("brk_start_timeout", n < 100, 1);
    repeat (50) @(negedge clk);
    #1;
    cfg_break = 1'b1;
    repeat (1000) @(negedge clk);
    #1;
    rel       = cyc;
    cfg_break = 1'b0;
    wait_quiet("brk_timeout", 200);
    s  = find_low(t0);
    dn = find_done(t0);
    check("brk_frame", frame_val(s, 16, 10), 542);
    check("brk_frame_len", dn - s, 159);
    check("brk_idle_gap", txd_log[idx(dn + 1)], 1);
    check("brk_low_start", txd_log[idx(dn + 2)], 0);
    check("brk_low_end", find_high(dn + 2), rel);
    check("brk_busy_end", find_not_busy(dn + 2), rel + 16);
    check("brk_no_done", count_done(dn + 1, cyc), 0);

    // Reset during the data bits of the second of three queued frames.
    @(negedge clk);
    #1;
    t0 = cyc;
    push(9'h011);
    push(9'h022);
    push(9'h033);
    repeat (220) @(negedge clk);
    #1;
    m   = cyc;
    rst = 1'b1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("rst2_ready", tx_ready, 1);
    check("rst2_txd", txd_log[idx(m)], 1);
    check("rst2_level", lvl_log[idx(m)], 0);
    check("rst2_busy", busy_log[idx(m)], 0);
    s  = find_low(t0);
    dn = find_done(t0);
    s2 = find_low(dn + 1);
    check("rst2_in_data", (s2 >= 0) && (m >= s2 + 16) && (m < s2 + 144), 1);
    repeat (300) @(negedge clk);
    #1;
    check("rst2_no_tx", find_low(m), -1);
    check("rst2_no_done", count_done(dn + 1, cyc), 0);
    run_frame("rst2_new", 16'd0, 4'd8, 2'b00, 1'b0, 9'h03C, 10, 632, s);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_gen2.md
UART_TX_GEN2 -- requirements
Module: uart_tx_gen2

Interface
REQ-001 SHALL have parameter DATA_MAX, default 9: widest data frame supported, legal range 8..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries, power of 2, minimum 2.
REQ-003 SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-004 SHALL have port clk, input, 1: the single clock.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port cfg_div, input, DIV_W: oversample tick every cfg_div+1 clocks; 16 ticks make one bit.
REQ-007 SHALL have port cfg_txen, input, 1: transmit enable.
REQ-008 SHALL have port cfg_dbits, input, 4: data bits per frame, 5..DATA_MAX.
REQ-009 SHALL have port cfg_parity, input, 2: 00 none, 01 even, 10 odd, 11 none.
REQ-010 SHALL have port cfg_nstop, input, 1: 0 gives one stop bit, 1 gives two.
REQ-011 SHALL have port cfg_break, input, 1: break request.
REQ-012 SHALL have ports tx_valid (input, 1), tx_data (input, DATA_MAX) and tx_ready (output, 1): write handshake.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-014 SHALL have port tx_busy, output, 1: high in any state other than IDLE.
REQ-015 SHALL have port tx_done, output, 1: one-cycle pulse at the end of each frame.
REQ-016 SHALL have port uart_txd, output, 1: serial line, idle high.

Function
REQ-017 SHALL push tx_data when tx_valid && tx_ready; tx_ready = (fifo_level < FIFO_DEPTH), combinational.
REQ-018 SHALL leave fifo_level unchanged on a simultaneous push and pop; a full FIFO SHALL never accept a push.
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-020 IDLE -> BREAK SHALL take priority when cfg_break=1; otherwise IDLE -> START SHALL occur when cfg_txen=1 and the FIFO is non-empty.
REQ-021 On IDLE -> START the block SHALL pop one word, latch cfg_dbits, cfg_parity and cfg_nstop, and clear the baud generator.
REQ-022 Configuration changes mid-frame SHALL have no effect on the current frame.
REQ-023 uart_txd SHALL go low the cycle after the pop.
REQ-024 Every bit SHALL last exactly 16*(cfg_div+1) clocks; cfg_div=0 gives 16 clocks per bit.
REQ-025 Data SHALL be sent LSB first; exactly cfg_dbits bits are sent, and tx_data bits above cfg_dbits SHALL be ignored.
REQ-026 cfg_dbits values below 5 SHALL be clamped to 5, and values above DATA_MAX clamped to DATA_MAX.
REQ-027 The PARITY state SHALL be skipped when parity is none.
REQ-028 Parity SHALL be computed over the transmitted data bits only: even = XOR of those bits; odd = inverted XOR.
REQ-029 STOP SHALL drive 1 for 1 or 2 bit times per the latched cfg_nstop.
REQ-030 tx_done SHALL pulse in the last cycle of the final stop bit, in the same cycle the FSM returns to IDLE.
REQ-031 Back-to-back frames SHALL have exactly 1 idle clock between the end of a stop bit and the next start bit.
REQ-032 cfg_txen deasserted mid-frame SHALL let the current frame complete and block further pops.
REQ-033 cfg_break asserted mid-frame SHALL take effect only after that frame's stop bit(s).
REQ-034 In BREAK, uart_txd SHALL be 0 while cfg_break=1.
REQ-035 After cfg_break falls, the block SHALL drive 1 for one bit time and then return to IDLE; tx_done SHALL NOT pulse for a break.

Reset
REQ-036 While rst=1: uart_txd=1, tx_busy=0, tx_done=0, fifo_level=0, FSM in IDLE, and FIFO pointers and baud counters cleared.
REQ-037 tx_ready SHALL be 1 in the first cycle after rst falls.
REQ-038 Reset mid-frame SHALL abort the frame, drive uart_txd high the cycle after rst is sampled, and discard FIFO contents.

Structure
REQ-039 Package uart_tx_gen2_pkg SHALL hold the FSM state enum, the parity encoding constants and OVS=16.
REQ-040 Sub-module uart_tx_baud_gen SHALL provide the divisor counter, a 4-bit tick counter, a clear input and a bit_end pulse.
REQ-041 The FIFO and parity logic SHALL be inline.

Verification
REQ-042 cfg_div=3, 8N1, push 0xA5: uart_txd = 0,1,0,1,0,0,1,0,1,1 at 64 clocks per bit; tx_done in cycle 640 after the pop.
REQ-043 7E2, push 0x55: start, 1010101 LSB first, parity 0, two stop bits; frame 11 bits long.
REQ-044 9O1, push 0x1FF: nine 1s, parity 0, one stop bit; 9N1 push 0x100: bit 8 = 1, no parity bit.
REQ-045 cfg_txen=0, push 9 words: tx_ready low after the 8th, fifo_level=8, 9th not accepted; set cfg_txen=1: 8 frames, each separated by 1 idle clock, fifo_level decrements at each pop.
REQ-046 Assert cfg_break mid-frame for 1000 clocks: the frame completes, then txd is low while cfg_break=1, then one bit of 1, then IDLE with no tx_done.
REQ-047 Assert rst during DATA of the 2nd of 3 queued frames: txd=1 the next cycle, fifo_level=0, no tx_done, and a new push transmits correctly.
